// File: rtl/decoder_if.sv
// rtl/decoder_if.sv - instruction in / decoded fields out bundle for decoder
interface decoder_if;
  logic        inst_valid;
  logic [31:0] inst;
  logic [2:0]  opcode;
  logic [4:0]  reg_addr_0;
  logic [4:0]  reg_addr_1;
  logic [4:0]  reg_addr_2;
  logic [15:0] addr;
  logic        out_valid;
  logic        illegal;

  // Instruction-register side: supplies words, consumes decoded fields
  modport master (
    output inst_valid, inst,
    input  opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr, out_valid, illegal
  );

  // Decoder side
  modport slave (
    input  inst_valid, inst,
    output opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr, out_valid, illegal
  );
endinterface

// File: rtl/decoder.sv
// rtl/decoder.sv - registered M/I/R instruction decoder; optional reserved-opcode trap via DECODER_ILLEGAL_TRAP_EN
module decoder (
  input logic      clk,
  input logic      rst,
  decoder_if.slave bus
);

  logic [2:0]  op;
  logic [4:0]  ra0_d, ra1_d, ra2_d;
  logic [15:0] addr_d;

  logic [2:0]  opcode_q;
  logic [4:0]  ra0_q, ra1_q, ra2_q;
  logic [15:0] addr_q;
  logic        out_valid_q;

  assign op = bus.inst[31:29];

`ifdef DECODER_ILLEGAL_TRAP_EN
  logic ill_d;
  logic ill_q;
`endif

  // Split the incoming word into fields according to its format; unused fields stay 0
  always_comb begin
    ra0_d  = 5'd0;
    ra1_d  = 5'd0;
    ra2_d  = 5'd0;
    addr_d = 16'd0;
`ifdef DECODER_ILLEGAL_TRAP_EN
    ill_d  = 1'b0;
`endif
    case (op)
      3'd0, 3'd1: begin
        ra0_d  = bus.inst[28:24];
        ra1_d  = bus.inst[20:16];
        addr_d = bus.inst[15:0];
      end
      3'd2: begin
        ra0_d  = bus.inst[28:24];
        ra1_d  = bus.inst[23:19];
        addr_d = {1'b0, bus.inst[14:0]};
      end
      3'd4: begin
        ra1_d  = bus.inst[28:24];
        ra2_d  = bus.inst[23:19];
        addr_d = {2'b0, bus.inst[13:0]};
      end
`ifdef DECODER_ILLEGAL_TRAP_EN
      // Reserved opcodes: flag them and leave every address field at 0
      default: ill_d = 1'b1;
`else
      // Without the trap, opcode 3 aliases format I and 5..7 alias format R
      3'd3: begin
        ra0_d  = bus.inst[28:24];
        ra1_d  = bus.inst[23:19];
        addr_d = {1'b0, bus.inst[14:0]};
      end
      default: begin
        ra1_d  = bus.inst[28:24];
        ra2_d  = bus.inst[23:19];
        addr_d = {2'b0, bus.inst[13:0]};
      end
`endif
    endcase
  end

  // Capture decoded fields on a strobe, hold otherwise; out_valid marks a fresh capture
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q    <= 3'd0;
      ra0_q       <= 5'd0;
      ra1_q       <= 5'd0;
      ra2_q       <= 5'd0;
      addr_q      <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.inst_valid;
      if (bus.inst_valid) begin
        opcode_q <= op;
        ra0_q    <= ra0_d;
        ra1_q    <= ra1_d;
        ra2_q    <= ra2_d;
        addr_q   <= addr_d;
      end
    end
  end

`ifdef DECODER_ILLEGAL_TRAP_EN
  // Illegal flag follows every accepted instruction
  always_ff @(posedge clk) begin
    if (rst)
      ill_q <= 1'b0;
    else if (bus.inst_valid)
      ill_q <= ill_d;
  end

  assign bus.illegal = ill_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.opcode     = opcode_q;
  assign bus.reg_addr_0 = ra0_q;
  assign bus.reg_addr_1 = ra1_q;
  assign bus.reg_addr_2 = ra2_q;
  assign bus.addr       = addr_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - randomized self-checking bench for decoder against a field-extraction model
`timescale 1ns/1ps
module tb_decoder;

  logic clk;
  logic rst;
  decoder_if dif ();

  decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Expected output state
  int e_op, e_r0, e_r1, e_r2, e_addr, e_ov, e_ill;

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Field extraction from the format rules using shifts and masks
  task automatic model_decode(input longint w);
    int o;
    o = int'((w >> 29) & 7);
    e_op = o; e_r0 = 0; e_r1 = 0; e_r2 = 0; e_addr = 0; e_ill = 0;
`ifndef DECODER_ILLEGAL_TRAP_EN
    if (o == 3) o = 2;
    if (o >= 5) o = 4;
`endif
    if (o == 0 || o == 1) begin
      e_r0 = int'((w >> 24) & 31);
      e_r1 = int'((w >> 16) & 31);
      e_addr = int'(w % 65536);
    end else if (o == 2) begin
      e_r0 = int'((w >> 24) & 31);
      e_r1 = int'((w >> 19) & 31);
      e_addr = int'(w % 32768);
    end else if (o == 4) begin
      e_r1 = int'((w >> 24) & 31);
      e_r2 = int'((w >> 19) & 31);
      e_addr = int'(w % 16384);
    end else begin
      e_ill = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".opcode"},     longint'(dif.opcode),     longint'(e_op));
    check({tag, ".reg_addr_0"}, longint'(dif.reg_addr_0), longint'(e_r0));
    check({tag, ".reg_addr_1"}, longint'(dif.reg_addr_1), longint'(e_r1));
    check({tag, ".reg_addr_2"}, longint'(dif.reg_addr_2), longint'(e_r2));
    check({tag, ".addr"},       longint'(dif.addr),       longint'(e_addr));
    check({tag, ".out_valid"},  longint'(dif.out_valid),  longint'(e_ov));
    check({tag, ".illegal"},    longint'(dif.illegal),    longint'(e_ill));
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge, check after it
  task automatic step(input string tag, input logic r, input logic v, input logic [31:0] w);
    @(negedge clk);
    rst = r;
    dif.inst_valid = v;
    dif.inst = w;
    @(posedge clk);
    if (r) begin
      e_op = 0; e_r0 = 0; e_r1 = 0; e_r2 = 0; e_addr = 0; e_ov = 0; e_ill = 0;
    end else if (v) begin
      model_decode(longint'(w));
      e_ov = 1;
    end else begin
      e_ov = 0;
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.inst_valid = 1'b0;
    dif.inst = 32'd0;

    step("reset", 1'b1, 1'b1, 32'hFFFF_FFFF);
    step("reset2", 1'b1, 1'b1, 32'hFFFF_FFFF);
    step("fmt_m", 1'b0, 1'b1, 32'h2B45_1234);
    step("fmt_m_drop", 1'b0, 1'b0, 32'hDEAD_BEEF);
    step("fmt_i", 1'b0, 1'b1, 32'h5AC4_FFFF);
    step("fmt_r", 1'b0, 1'b1, 32'h9F8F_FFFF);
    step("rsv3", 1'b0, 1'b1, 32'h7FFF_FFFF);
    step("rsv5", 1'b0, 1'b1, 32'hBFFF_FFFF);
    step("rsv7", 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("b2b0", 1'b0, 1'b1, 32'h0000_0000);
    step("b2b1", 1'b0, 1'b1, 32'h2000_0000);
    step("hold0", 1'b0, 1'b0, 32'hFFFF_FFFF);
    step("hold1", 1'b0, 1'b0, 32'h1234_5678);
    step("rst_mid", 1'b1, 1'b1, 32'h9F8F_FFFF);

    for (int i = 0; i < 400; i++) begin
      logic r, v;
      logic [31:0] w;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = $urandom;
      step("rand", r, v, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
